// File: rtl/ram_master.sv
// ram_master: serialises core byte/half/word loads and stores onto a single-port word RAM
module ram_master #(
  parameter int ADDR_W = 14
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [31:0]       ram_store,
  input  logic [31:0]       ram_load
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, RMW_RD, RMW_MRG, RMW_WR, RESP} state_t;

  state_t              state_q;
  logic [1:0]          size_q;
  logic [1:0]          lane_q;
  logic                uns_q;
  logic [15:0]         wdata_q;
  logic                req_ready_q;
  logic                resp_valid_q;
  logic                resp_err_q;
  logic [31:0]         resp_rdata_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic                ram_wen_q;
  logic [31:0]         ram_store_q;
  logic                acc_err;
  logic [7:0]          ld_b;
  logic [15:0]         ld_h;
  logic [31:0]         rd_fmt;
  logic [31:0]         mrg_mask;
  logic [31:0]         mrg_ins;
  logic [31:0]         merged;

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign ram_addr   = ram_addr_q;
  assign ram_wen    = ram_wen_q;
  assign ram_store  = ram_store_q;

  // Request legality, load lane extraction/extension and store lane merge
  always_comb begin
    acc_err  = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
               (req_size == 2'd2 && req_addr[1:0] != 2'd0) || ((req_addr >> (ADDR_W + 2)) != 32'd0);
    ld_b     = ram_load[{lane_q, 3'b000} +: 8];
    ld_h     = ram_load[{lane_q[1], 4'b0000} +: 16];
    rd_fmt   = size_q == 2'd0 ? {{24{ld_b[7] & ~uns_q}}, ld_b} :
               size_q == 2'd1 ? {{16{ld_h[15] & ~uns_q}}, ld_h} : ram_load;
    mrg_mask = size_q == 2'd0 ? 32'hFF << {lane_q, 3'b000} : 32'hFFFF << {lane_q[1], 4'b0000};
    mrg_ins  = size_q == 2'd0 ? {4{wdata_q[7:0]}} : {2{wdata_q}};
    merged   = (ram_load & ~mrg_mask) | (mrg_ins & mrg_mask);
  end

  // Control FSM with all outputs registered; reset aborts any operation in flight
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      size_q       <= 2'd0;
      lane_q       <= 2'd0;
      uns_q        <= 1'b0;
      wdata_q      <= 16'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      ram_addr_q   <= '0;
      ram_wen_q    <= 1'b0;
      ram_store_q  <= 32'd0;
    end else begin
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      ram_wen_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            size_q     <= req_size;
            lane_q     <= req_addr[1:0];
            uns_q      <= req_unsigned;
            wdata_q    <= req_wdata[15:0];
            ram_addr_q <= req_addr[ADDR_W+1:2];
            if (acc_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_wen) begin
              state_q <= RD_ADDR;
            end else if (req_size == 2'd2) begin
              state_q     <= WR;
              ram_wen_q   <= 1'b1;
              ram_store_q <= req_wdata;
            end else begin
              state_q <= RMW_RD;
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        RD_ADDR: state_q <= RD_DATA;
        RD_DATA: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= rd_fmt;
        end
        RMW_RD: state_q <= RMW_MRG;
        RMW_MRG: begin
          state_q     <= RMW_WR;
          ram_wen_q   <= 1'b1;
          ram_store_q <= merged;
        end
        WR, RMW_WR: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 Parameter: ADDR_W, default 14, RAM word-address width; RAM holds 2^ADDR_W 32-bit words.
REQ-002 CLK  input  1  single clock for this block and the RAM it drives.
REQ-003 nRST  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  core request present.
REQ-005 req_ready  output  1  block idle and able to accept a request.
REQ-006 req_wen  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-008 req_unsigned  input  1  zero-extend sub-word loads; ignored for stores and word loads.
REQ-009 req_addr  input  32  byte address, little-endian.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_err  output  1  request rejected; valid with resp_valid.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 ram_addr  output  ADDR_W  word address to RAM (cpu_ram_if ram_addr).
REQ-015 ram_wen  output  1  RAM write enable (cpu_ram_if ram_wen).
REQ-016 ram_store  output  32  RAM write data (cpu_ram_if ram_store).
REQ-017 ram_load  input  32  RAM read data, valid one edge after ram_addr is sampled with ram_wen=0 (cpu_ram_if ram_load).

Function
REQ-018 FSM states: IDLE, RD_ADDR, RD_DATA, WR, RMW_RD, RMW_MRG, RMW_WR, RESP.
REQ-019 req_ready = 1 only in IDLE; a request is accepted on an edge where req_valid and req_ready are both 1; all req_* fields are latched at acceptance, and later changes are ignored.
REQ-020 Error on acceptance: size 3; half with addr[0]=1; word with addr[1:0]!=0; any req_addr bit above ADDR_W+1 set -> go to RESP with resp_err=1; no RAM access.
REQ-021 Word index = req_addr[ADDR_W+1:2]; ram_addr holds this value in every non-IDLE state and keeps its last value in IDLE.
REQ-022 Load: accepted on edge t -> RD_ADDR -> (t+1) RD_DATA -> (t+2) RESP; resp_valid=1 between edges t+2 and t+3.
REQ-023 Load formatting: byte lane addr[1:0], half lane addr[1]; sign-extend unless req_unsigned; word returned unchanged; the result is registered into resp_rdata on entry to RESP.
REQ-024 Word store: accepted on edge t -> WR (ram_wen=1, ram_store=wdata) -> (t+1) RESP.
REQ-025 Sub-word store: RMW_RD (ram_wen=0) -> RMW_MRG (ram_load merged into a register) -> RMW_WR (ram_wen=1, ram_store=merged word) -> RESP; resp_valid between edges t+3 and t+4.
REQ-026 Merge: byte lane k = addr[1:0] has bits 8k+7:8k replaced by wdata[7:0]; half lane h = addr[1] has bits 16h+15:16h replaced by wdata[15:0]; all other bits are preserved.
REQ-027 ram_wen = 1 only in WR and RMW_WR, for exactly one cycle per store.
REQ-028 RESP lasts exactly one cycle and is always followed by IDLE; back-to-back requests incur one IDLE cycle.
REQ-029 resp_err = 0 whenever resp_valid = 0; resp_rdata = 0 for store and error responses.

Reset
REQ-030 While nRST=0: state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_wen=0, ram_addr=0, ram_store=0 (asynchronous).
REQ-031 Reset asserted mid-operation aborts the operation; ram_wen drops immediately; no response is issued; a pending RMW write is never performed.

Verification
REQ-032 Reset release with req_valid=0 -> req_ready=1, ram_wen=0, resp_valid never asserted.
REQ-033 Store word 0xDEADBEEF @0x10 -> ram_addr=4, one ram_wen pulse, resp_valid at t+1; load word @0x10 -> resp_rdata=0xDEADBEEF at t+2.
REQ-034 Store byte 0x80 @0x11 -> RAM word 4 = 0xDEAD80EF; load byte @0x11 -> 0xFFFFFF80; load byte unsigned -> 0x00000080.
REQ-035 Store half 0x1234 @0x12 -> word 0x123480EF; load half @0x13 -> resp_err=1, resp_rdata=0, no ram_wen, resp_valid at t.
REQ-036 Load word @(1<<(ADDR_W+2)) -> resp_err=1; size=3 -> resp_err=1.
REQ-037 nRST pulsed during RMW_MRG of a byte store @0x10 -> no ram_wen, no resp_valid; a subsequent load word @0x10 returns the pre-store value.
